alarm_ringer: RTL and testbench

ALARM_RINGER -- requirements
Module: alarm_ringer

---
 rtl/alarm_ringer.sv | 174 +++++++++++++++++
 tb/tb_alarm_ringer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ringer.sv
// alarm_ringer: alarm clock ring / snooze / dismiss controller.
//
// Raises ringing when the current time reaches the alarm time, on a
// tick_1hz cycle with cur_seconds == 0. Ringing stops on dismiss, on
// auto-stop after RING_SEC ticks, or when the alarm becomes invalid.
// The optional snooze feature is enabled by defining ALARM_SNOOZE_EN.
// A snooze pauses ringing for SNOOZE_SEC ticks, at most MAX_SNOOZE
// times per alarm event.
//
// Parameters:
//   RING_SEC    ticks a ring lasts before auto-stop (1..511)
//   SNOOZE_SEC  ticks from snooze entry to re-ring (1..511)
//   MAX_SNOOZE  snoozes accepted per alarm event (0..3)
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   tick_1hz       one-cycle pulse per second
//   cur_hours      current hour, 0..23
//   cur_minutes    current minute, 0..59
//   cur_seconds    current second, 0..59
//   alarm_hours    alarm hour; 24 or above means no alarm set
//   alarm_minutes  alarm minute; 60 or above is invalid
//   snooze         snooze button pulse
//   dismiss        dismiss button pulse
//   ringing        registered, high while ringing
//   snoozing       registered, high while snoozing (0 without snooze)
//   buzz           registered, ringing gated by the per-tick phase bit
//   snooze_count   snoozes taken this event (0 without snooze)
module alarm_ringer #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    input  logic [5:0] cur_seconds,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    input  logic       snooze,
    input  logic       dismiss,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzz,
    output logic [1:0] snooze_count
);

    localparam logic [8:0] RING_LAST = 9'(RING_SEC - 1);

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RINGING} state_t;
`endif

    state_t     state;
    logic [8:0] ring_cnt;
    logic       phase;
    logic       alarm_valid;
    logic       trigger;

    assign alarm_valid = (alarm_hours < 5'd24) && (alarm_minutes < 6'd60);
    assign trigger     = tick_1hz && alarm_valid &&
                         (cur_hours == alarm_hours) &&
                         (cur_minutes == alarm_minutes) &&
                         (cur_seconds == 6'd0);

`ifdef ALARM_SNOOZE_EN
    logic [8:0] snz_cnt;
    logic [1:0] taken;
    logic       snooze_ok;

    assign snooze_ok    = snooze && (taken < 2'(MAX_SNOOZE));
    assign snooze_count = taken;
`else
    // Snooze is compiled out: the input and its parameters have no effect.
    logic unused_snooze_cfg;
    assign unused_snooze_cfg = snooze ^ (SNOOZE_SEC > 0) ^ (MAX_SNOOZE > 0);
    assign snoozing          = 1'b0;
    assign snooze_count      = 2'b00;
`endif

    // Abort (invalid alarm, then dismiss) is checked before snooze, and
    // snooze before the tick-driven transitions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ring_cnt <= '0;
            phase    <= 1'b0;
            ringing  <= 1'b0;
            buzz     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt  <= '0;
            taken    <= '0;
            snoozing <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state    <= RINGING;
                        ring_cnt <= '0;
                        phase    <= 1'b0;
                        ringing  <= 1'b1;
                        buzz     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                        taken    <= '0;
`endif
                    end
                end
                RINGING: begin
                    if (!alarm_valid || dismiss) begin
                        state   <= IDLE;
                        ringing <= 1'b0;
                        buzz    <= 1'b0;
                    end
`ifdef ALARM_SNOOZE_EN
                    else if (snooze_ok) begin
                        state    <= SNOOZE;
                        snz_cnt  <= 9'(SNOOZE_SEC);
                        taken    <= taken + 2'd1;
                        ringing  <= 1'b0;
                        buzz     <= 1'b0;
                        snoozing <= 1'b1;
                    end
`endif
                    else if (tick_1hz) begin
                        if (ring_cnt == RING_LAST) begin
                            state   <= IDLE;
                            ringing <= 1'b0;
                            buzz    <= 1'b0;
                        end else begin
                            ring_cnt <= ring_cnt + 9'd1;
                            phase    <= ~phase;
                            buzz     <= ~phase;
                        end
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (!alarm_valid || dismiss) begin
                        state    <= IDLE;
                        snoozing <= 1'b0;
                    end else if (tick_1hz) begin
                        // Counter was loaded with SNOOZE_SEC, so the tick
                        // seeing 1 is the SNOOZE_SEC-th tick.
                        if (snz_cnt == 9'd1) begin
                            state    <= RINGING;
                            ring_cnt <= '0;
                            phase    <= 1'b0;
                            ringing  <= 1'b1;
                            buzz     <= 1'b0;
                            snoozing <= 1'b0;
                        end else begin
                            snz_cnt <= snz_cnt - 9'd1;
                        end
                    end
                end
`endif
                default: begin
                    state   <= IDLE;
                    ringing <= 1'b0;
                    buzz    <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                    snoozing <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_ringer.sv
// Testbench for alarm_ringer (RING_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=1).
// Follows ALARM_SNOOZE_EN if defined. Directed scenarios are followed by
// random stimulus, checked against a remaining-ticks reference model.
module tb_alarm_ringer;
    localparam int RING_SEC   = 4;
    localparam int SNOOZE_SEC = 3;
    localparam int MAX_SNOOZE = 1;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       snooze = 1'b0;
    logic       dismiss = 1'b0;
    logic [4:0] cur_hours = '0;
    logic [5:0] cur_minutes = '0;
    logic [5:0] cur_seconds = '0;
    logic [4:0] alarm_hours = 5'd24;
    logic [5:0] alarm_minutes = '0;
    logic       ringing, snoozing, buzz;
    logic [1:0] snooze_count;

    int n_chk = 0;
    int n_err = 0;

    // Model: mode 0 idle, 1 ring, 2 snooze; counts remaining ticks.
    int m_mode, m_ring_left, m_snz_left, m_rung, m_taken;

    alarm_ringer #(
        .RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC), .MAX_SNOOZE(MAX_SNOOZE)
    ) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
        .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
        .snooze(snooze), .dismiss(dismiss),
        .ringing(ringing), .snoozing(snoozing), .buzz(buzz),
        .snooze_count(snooze_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_ring_left = 0; m_snz_left = 0; m_rung = 0; m_taken = 0;
    endtask

    task automatic start_ring();
        m_mode = 1; m_ring_left = RING_SEC; m_rung = 0;
    endtask

    task automatic model_step();
        bit valid;
        if (reset) begin
            model_reset();
            return;
        end
        valid = (alarm_hours <= 23) && (alarm_minutes <= 59);
        case (m_mode)
            0: if (tick_1hz && valid && cur_hours == alarm_hours &&
                   cur_minutes == alarm_minutes && cur_seconds == 0) begin
                start_ring();
                m_taken = 0;
            end
            1: if (!valid || dismiss) m_mode = 0;
               else if (SNZ_EN && snooze && m_taken < MAX_SNOOZE) begin
                   m_mode = 2; m_snz_left = SNOOZE_SEC; m_taken++;
               end else if (tick_1hz) begin
                   m_ring_left--; m_rung++;
                   if (m_ring_left == 0) m_mode = 0;
               end
            default: if (!valid || dismiss) m_mode = 0;
               else if (tick_1hz) begin
                   m_snz_left--;
                   if (m_snz_left == 0) start_ring();
               end
        endcase
    endtask

    task automatic check_all();
        chk("ringing", ringing, m_mode == 1);
        chk("snoozing", snoozing, m_mode == 2);
        chk("buzz", buzz, (m_mode == 1) && (m_rung % 2 == 1));
        chk("snz_count", snooze_count, m_taken);
    endtask

    // One clock: drive inputs, update model at the edge, compare mid-cycle.
    task automatic step(input logic t, input logic s, input logic d);
        tick_1hz = t; snooze = s; dismiss = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        tick_1hz = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_hours = 5'(h); cur_minutes = 6'(m); cur_seconds = 6'(s);
    endtask

    task automatic set_alarm(input int h, input int m);
        alarm_hours = 5'(h); alarm_minutes = 6'(m);
    endtask

    task automatic trigger_0730();
        set_alarm(7, 30);
        set_time(7, 30, 0);
        step(1'b1, 1'b0, 1'b0);
        set_time(7, 30, 1);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        chk("rst_ringing", ringing, 1'b0);
        chk("rst_snoozing", snoozing, 1'b0);
        chk("rst_buzz", buzz, 1'b0);
        chk("rst_count", snooze_count, 2'd0);
        reset = 1'b0;

        // Trigger, buzz toggling, auto-stop after 4 ticks.
        set_alarm(7, 30);
        set_time(7, 29, 59);
        step(1'b1, 1'b0, 1'b0);
        chk("early_no_ring", ringing, 1'b0);
        trigger_0730();
        chk("trig_ring", ringing, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end
        chk("autostop", ringing, 1'b0);

        // Invalid alarms never trigger.
        set_alarm(24, 0); set_time(0, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        chk("inv_hours", ringing, 1'b0);
        set_alarm(7, 60); set_time(7, 60, 0);
        step(1'b1, 1'b0, 1'b0);
        chk("inv_minutes", ringing, 1'b0);

        // Snooze, re-ring, second snooze ignored, auto-stop.
        trigger_0730();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("snz_enter", snoozing, SNZ_EN);
        chk("snz_taken", snooze_count, SNZ_EN ? 2'd1 : 2'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        chk("rering", ringing, SNZ_EN);
        step(1'b0, 1'b1, 1'b0);
        chk("snz_max_ignored", snoozing, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        chk("stop_after_rering", ringing, 1'b0);

        // Snooze and dismiss together while ringing.
        trigger_0730();
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("sd_ringing", ringing, 1'b0);
        chk("sd_count", snooze_count, SNZ_EN ? 2'd1 : 2'd0);
        trigger_0730();
        step(1'b1, 1'b1, 1'b1);
        chk("sd_fresh_count", snooze_count, 2'd0);

        // Alarm cleared during snooze: no re-ring.
        trigger_0730();
        step(1'b0, 1'b1, 1'b0);
        alarm_hours = 5'd24;
        step(1'b0, 1'b0, 1'b0);
        chk("clr_snoozing", snoozing, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        chk("clr_no_rering", ringing, 1'b0);

        // Async reset mid-ring.
        trigger_0730();
        step(1'b1, 1'b0, 1'b0);
        chk("pre_rst_buzz", buzz, 1'b1);
        reset = 1'b1;
        #1;
        chk("arst_ringing", ringing, 1'b0);
        chk("arst_buzz", buzz, 1'b0);
        chk("arst_snoozing", snoozing, 1'b0);
        model_reset();
        step(1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        chk("post_rst_no_ring", ringing, 1'b0);

        // Random stimulus against the model.
        set_alarm(7, 30);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                alarm_hours = 5'($urandom_range(0, 25));
                alarm_minutes = ($urandom_range(0, 7) == 0) ?
                                6'(60 + $urandom_range(0, 3)) : 6'($urandom_range(0, 59));
            end
            if ($urandom_range(0, 3) == 0) begin
                cur_hours = alarm_hours; cur_minutes = alarm_minutes; cur_seconds = 6'd0;
            end else begin
                set_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                         int'($urandom_range(0, 59)));
            end
            reset = ($urandom_range(0, 255) == 0);
            step(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 15) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
